// File: rtl/store_align_buffer_pkg.sv
// Shared types and alignment helpers for the store alignment buffer.
package store_buf_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} st_size_e;

  // Strobe is computed at 8-lane width; narrower datapaths use the overflow as a crossing check.
  function automatic logic [7:0] calc_strb(st_size_e size, logic [2:0] off);
    logic [7:0] base;
    unique case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic is_misaligned(st_size_e size, logic [2:0] off, int xlen);
    unique case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return (off != 3'd0) || (xlen != 64);
    endcase
  endfunction

endpackage

// File: rtl/store_align_buffer_if.sv
// LSU-side store request, memory-side head entry and load hazard probe.
interface store_align_buffer_if #(parameter int XLEN = 32, parameter int DEPTH = 4);
  localparam int NB = XLEN / 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic            i_st_valid;
  logic            o_st_ready;
  logic [XLEN-1:0] i_st_addr;
  logic [XLEN-1:0] i_st_data;
  logic [1:0]      i_st_size;
  logic            o_misalign;
  logic            o_mem_valid;
  logic            i_mem_ready;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic [NB-1:0]   o_mem_strb;
  logic [XLEN-1:0] i_ld_addr;
  logic            o_ld_hit;
  logic [CW-1:0]   o_count;

  modport master (
    output i_st_valid, i_st_addr, i_st_data, i_st_size, i_mem_ready, i_ld_addr,
    input  o_st_ready, o_misalign, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_strb,
           o_ld_hit, o_count
  );

  modport slave (
    input  i_st_valid, i_st_addr, i_st_data, i_st_size, i_mem_ready, i_ld_addr,
    output o_st_ready, o_misalign, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_strb,
           o_ld_hit, o_count
  );
endinterface

// File: rtl/store_align_buffer_lane_align.sv
// Combinational lane alignment: shifts right-justified store data into its byte lanes.
module store_lane_align
  import store_buf_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [OFFW-1:0] i_off,
  input  logic [XLEN-1:0] i_data,
  input  st_size_e        i_size,
  output logic [XLEN-1:0] o_wdata,
  output logic [NB-1:0]   o_strb,
  output logic            o_misalign
);

  logic [7:0]      w_strb_full;
  logic [XLEN-1:0] w_mask;

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < NB; b++)
      w_mask[8*b +: 8] = (b < (1 << int'(i_size))) ? 8'hFF : 8'h00;
    w_strb_full = calc_strb(i_size, 3'(i_off));
    o_wdata     = (i_data & w_mask) << {i_off, 3'b000};
    o_strb      = w_strb_full[NB-1:0];
    // Any strobe spilling past the top lane also means the access is illegal here.
    o_misalign  = is_misaligned(i_size, 3'(i_off), XLEN) | (|(16'(w_strb_full) >> NB));
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store FIFO between LSU and memory with lane alignment, newest-entry coalescing and load hazard flag.
module store_align_buffer
  import store_buf_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int COALESCE = 1
) (
  input logic                i_clk,
  input logic                i_rst_n,
  store_align_buffer_if.slave bus
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [NB-1:0]   strb;
  } sb_entry_t;

  sb_entry_t       r_q [DEPTH];
  logic [PW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_count;
  logic            r_misalign;

  logic [XLEN-1:0] w_wdata;
  logic [NB-1:0]   w_strb;
  logic            w_mis, w_empty, w_pop, w_coal, w_ready, w_acc, w_push, w_ld_hit;
  logic [PW-1:0]   w_new;
  logic [PW-1:0]   w_age [DEPTH];

  store_lane_align #(.XLEN(XLEN)) u_align (
    .i_off      (bus.i_st_addr[OFFW-1:0]),
    .i_data     (bus.i_st_data),
    .i_size     (st_size_e'(bus.i_st_size)),
    .o_wdata    (w_wdata),
    .o_strb     (w_strb),
    .o_misalign (w_mis)
  );

  assign w_new   = r_wr - PW'(1);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty & bus.i_mem_ready;
  // The newest entry must not be draining this cycle, otherwise the merge would be lost.
  assign w_coal  = (COALESCE != 0) & !w_mis & !w_empty
                 & (((r_q[w_new].addr ^ bus.i_st_addr) >> OFFW) == '0)
                 & !((r_count == CW'(1)) & w_pop);
  assign w_ready = (r_count < CW'(DEPTH)) | w_coal;
  assign w_acc   = bus.i_st_valid & w_ready;
  assign w_push  = w_acc & !w_mis & !w_coal;

  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    assign w_age[i] = PW'(i) - r_rd;
  end

  always_comb begin
    w_ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ((CW'(w_age[i]) < r_count) && (((r_q[i].addr ^ bus.i_ld_addr) >> OFFW) == '0))
        w_ld_hit = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      r_misalign <= w_acc & w_mis;
      if (w_push) begin
        r_q[r_wr] <= '{addr: {bus.i_st_addr[XLEN-1:OFFW], OFFW'(0)}, wdata: w_wdata, strb: w_strb};
        r_wr      <= r_wr + PW'(1);
      end
      if (w_acc & w_coal) begin
        for (int b = 0; b < NB; b++)
          if (w_strb[b]) r_q[w_new].wdata[8*b +: 8] <= w_wdata[8*b +: 8];
        r_q[w_new].strb <= r_q[w_new].strb | w_strb;
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.o_st_ready  = w_ready;
  assign bus.o_misalign  = r_misalign;
  assign bus.o_mem_valid = !w_empty;
  assign bus.o_mem_addr  = w_empty ? '0 : r_q[r_rd].addr;
  assign bus.o_mem_wdata = w_empty ? '0 : r_q[r_rd].wdata;
  assign bus.o_mem_strb  = w_empty ? '0 : r_q[r_rd].strb;
  assign bus.o_ld_hit    = w_ld_hit;
  assign bus.o_count     = r_count;

endmodule
